// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, port encoding and XY routing.
// The same routing function is used by the router RTL and its checkers.
package noc_pkg;

   localparam int FLIT_W    = 73;
   localparam int COORD_W   = 4;
   localparam int PAYLOAD_W = 64;
   localparam int TAIL_BIT  = 72;
   localparam int DX_HI     = 71;
   localparam int DX_LO     = 68;
   localparam int DY_HI     = 67;
   localparam int DY_LO     = 64;

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      EAST  = 3'd2,
      SOUTH = 3'd3,
      WEST  = 3'd4
   } port_e;

   // Dimension-ordered routing: resolve X first, then Y.
   function automatic port_e xy_route(input logic [COORD_W-1:0] dest_x,
                                      input logic [COORD_W-1:0] dest_y,
                                      input logic [COORD_W-1:0] cur_x,
                                      input logic [COORD_W-1:0] cur_y);
      port_e p;
      if (dest_x > cur_x)      p = EAST;
      else if (dest_x < cur_x) p = WEST;
      else if (dest_y > cur_y) p = NORTH;
      else if (dest_y < cur_y) p = SOUTH;
      else                     p = LOCAL;
      return p;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready on both sides and an occupancy count.
// No fall-through and no full bypass: a pop never frees space in the same cycle.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 73
) (
   input  logic                       i_clk,
   input  logic                       i_arst_n,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_ready = (r_count != FULL_CNT);
   assign o_valid = (r_count != '0);
   assign w_push  = i_valid && o_ready;
   assign w_pop   = o_valid && i_ready;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset; stale entries are never visible while empty.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_arst_n)
      !(i_valid && (r_count == FULL_CNT) && w_push));
   a_count_bound: assert property (@(posedge i_clk) disable iff (!i_arst_n)
      r_count <= FULL_CNT);

endmodule

// File: rtl/router_input_port.sv
// Router input stage: buffers one link's flits and steers the head flit
// to the arbiter of its XY-routed output port via a one-hot request.
module router_input_port
   import noc_pkg::*;
#(
   parameter int                 DEPTH       = 4,
   parameter int                 WIDTH       = 73,
   parameter int                 NUM_OUTPUTS = 5,
   parameter logic [COORD_W-1:0] ROUTER_X    = '0,
   parameter logic [COORD_W-1:0] ROUTER_Y    = '0
) (
   input  logic                       i_clk,
   input  logic                       i_arst_n,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic [WIDTH-1:0]           o_data,
   output logic [NUM_OUTPUTS-1:0]     o_valid,
   input  logic [NUM_OUTPUTS-1:0]     i_ready,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   logic [WIDTH-1:0]       w_head;
   logic                   w_head_valid;
   logic                   w_pop;
   port_e                  w_route;
   logic [NUM_OUTPUTS-1:0] w_req;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_data   (i_data),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .o_data   (w_head),
      .o_valid  (w_head_valid),
      .i_ready  (w_pop),
      .o_count  (o_count)
   );

   assign w_route = xy_route(w_head[DX_HI:DX_LO], w_head[DY_HI:DY_LO], ROUTER_X, ROUTER_Y);

   // Only the selected arbiter's accept can pop; other i_ready bits are masked.
   always_comb begin
      w_req = '0;
      if (w_head_valid) w_req = NUM_OUTPUTS'(1) << w_route;
   end

   assign o_valid = w_req;
   assign w_pop   = |(w_req & i_ready);
   assign o_data  = w_head;

   a_onehot_valid: assert property (@(posedge i_clk) disable iff (!i_arst_n)
      $onehot0(o_valid));

endmodule

// File: tb/tb_router_input_port.sv
// Scoreboard bench for router_input_port at router coordinate (1,1), DEPTH 4.
module tb_router_input_port;
   import noc_pkg::*;

   localparam int         DEPTH = 4;
   localparam logic [3:0] RX    = 4'd1;
   localparam logic [3:0] RY    = 4'd1;

   logic        i_clk = 1'b0;
   logic        i_arst_n = 1'b0;
   logic [72:0] i_data = '0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [72:0] o_data;
   logic [4:0]  o_valid;
   logic [4:0]  i_ready = '0;
   logic [2:0]  o_count;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [72:0] sb_q[$];
   logic [72:0] held;

   router_input_port #(
      .DEPTH       (DEPTH),
      .WIDTH       (73),
      .NUM_OUTPUTS (5),
      .ROUTER_X    (RX),
      .ROUTER_Y    (RY)
   ) dut (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_data   (i_data),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_count  (o_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [72:0] mk_flit(input logic [3:0] dx, input logic [3:0] dy,
                                           input logic [63:0] pl);
      return {1'b0, dx, dy, pl};
   endfunction

   function automatic logic [4:0] exp_req(input logic [72:0] f);
      port_e p;
      p = xy_route(f[71:68], f[67:64], RX, RY);
      return 5'b00001 << int'(p);
   endfunction

   // Drive one cycle at the falling edge, check outputs against the model,
   // then update the model with what the rising edge will do.
   task automatic cycle(input logic v, input logic [72:0] d, input logic [4:0] rdy);
      logic [4:0] ev;
      logic       push;
      logic       pop;
      @(negedge i_clk);
      i_valid = v;
      i_data  = d;
      i_ready = rdy;
      #1;
      ev = (sb_q.size() == 0) ? 5'b0 : exp_req(sb_q[0]);
      check("count", 73'(o_count), 73'(sb_q.size()));
      check("ready", 73'(o_ready), 73'(sb_q.size() != DEPTH));
      check("valid", 73'(o_valid), 73'(ev));
      push = v && (sb_q.size() != DEPTH);
      pop  = |(ev & rdy);
      if (pop) begin
         check("pop_data", o_data, sb_q[0]);
         void'(sb_q.pop_front());
      end
      if (push) sb_q.push_back(d);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 5'b11111);
   endtask

   logic [72:0] corners [4];
   logic [4:0]  corner_oh [4];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset only
      repeat (2) @(negedge i_clk);
      #1;
      check("rst_ready", 73'(o_ready), 73'(1));
      check("rst_valid", 73'(o_valid), 73'(5'b00000));
      check("rst_count", 73'(o_count), 73'(0));
      @(negedge i_clk);
      i_arst_n = 1'b1;

      // Single EAST flit, held for 3 cycles, then accepted
      held = mk_flit(4'd3, 4'd0, 64'hDEAD_BEEF_0000_0001);
      cycle(1'b1, held, 5'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 5'b0);
         check("hold_valid", 73'(o_valid), 73'(5'b00100));
         check("hold_data", o_data, held);
      end
      cycle(1'b0, '0, 5'b00100);
      cycle(1'b0, '0, 5'b0);
      check("after_pop_count", 73'(o_count), 73'(0));

      // Fill to DEPTH, then pop while upstream keeps offering
      for (int i = 0; i < DEPTH; i++)
         cycle(1'b1, mk_flit(4'd3, 4'd0, 64'(100 + i)), 5'b0);
      cycle(1'b1, mk_flit(4'd3, 4'd0, 64'd104), 5'b0);
      check("full_count", 73'(o_count), 73'(4));
      check("full_ready", 73'(o_ready), 73'(0));
      cycle(1'b1, mk_flit(4'd3, 4'd0, 64'd104), 5'b00100);
      check("full_pop_ready", 73'(o_ready), 73'(0));
      cycle(1'b1, mk_flit(4'd3, 4'd0, 64'd104), 5'b0);
      check("reopen_ready", 73'(o_ready), 73'(1));
      drain(5);
      check("drained_count", 73'(o_count), 73'(0));

      // Route corners at (1,1)
      corners[0] = mk_flit(4'd1, 4'd2, 64'hA0); corner_oh[0] = 5'b00010;
      corners[1] = mk_flit(4'd1, 4'd0, 64'hA1); corner_oh[1] = 5'b01000;
      corners[2] = mk_flit(4'd0, 4'd1, 64'hA2); corner_oh[2] = 5'b10000;
      corners[3] = mk_flit(4'd1, 4'd1, 64'hA3); corner_oh[3] = 5'b00001;
      for (int i = 0; i < 4; i++) cycle(1'b1, corners[i], 5'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, 5'b11111);
         check("corner_oh", 73'(o_valid), 73'(corner_oh[i]));
         check("corner_data", o_data, corners[i]);
      end
      cycle(1'b0, '0, 5'b0);

      // Steady push+pop at occupancy 2; masked accepts never pop
      cycle(1'b1, mk_flit(4'd3, 4'd0, 64'd0), 5'b0);
      cycle(1'b1, mk_flit(4'd3, 4'd0, 64'd1), 5'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 5'b11011);
         check("masked_count", 73'(o_count), 73'(2));
      end
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, mk_flit(4'd3, 4'd0, 64'(i + 2)), 5'b11111);
         check("steady_count", 73'(o_count), 73'(2));
         check("steady_payload", 73'(o_data[63:0]), 73'(i));
      end
      drain(3);

      // Asynchronous reset with 3 flits queued
      for (int i = 0; i < 3; i++) cycle(1'b1, mk_flit(4'd2, 4'd1, 64'(200 + i)), 5'b0);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 5'b0;
      #2;
      i_arst_n = 1'b0;
      #1;
      check("arst_valid", 73'(o_valid), 73'(5'b00000));
      check("arst_count", 73'(o_count), 73'(0));
      check("arst_ready", 73'(o_ready), 73'(1));
      sb_q.delete();
      @(negedge i_clk);
      i_arst_n = 1'b1;
      held = mk_flit(4'd1, 4'd3, 64'h5A5A);
      cycle(1'b1, held, 5'b0);
      cycle(1'b0, '0, 5'b0);
      check("post_rst_head", o_data, held);
      check("post_rst_valid", 73'(o_valid), 73'(5'b00010));
      drain(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
